instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  IF stage of the single-issue MIPS pipeline, directly upstream of Control_Unit.
//  - Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
//  - Registers the IF/ID pair {instr, pc+4}; op_out/func_out feed Control_Unit op_in/func_in.
//  - Takes PC redirects from taken branches (branch_in) and jumps (jump_in).
//  - Inserts bubbles on memory wait or flush; freezes on stall_in.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded at reset
//  NOP_INSTR  32'h0000_0000  instruction driven while valid_out=0 (sll $0,$0,0)
// PORTS
//  clk_in           in   1   single clock, rising edge
//  rst_n_in         in   1   reset, synchronous, active-low
//  stall_in         in   1   hazard stall: hold IF/ID and PC
//  branch_in        in   1   taken branch, older instr, 1-cycle pulse
//  branch_target_in in   32  branch target address
//  jump_in          in   1   jump decoded from current IF/ID (Control_Unit jump_out)
//  jump_index_in    in   26  instr[25:0] of the jump
//  imem_req_out     out  1   fetch request
//  imem_addr_out    out  32  fetch address, word aligned
//  imem_ack_in      in   1   imem_data_in valid this cycle; any latency >= 0 cycles
//  imem_data_in     in   32  fetched word
//  instr_out        out  32  IF/ID instruction
//  pc_plus4_out     out  32  IF/ID pc+4
//  op_out           out  6   instr_out[31:26]
//  func_out         out  6   instr_out[5:0]
//  valid_out        out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (rst_n_in=0 at clk edge, overrides all inputs, valid mid-transaction):
//   pc=RESET_PC, state=IDLE, valid_out=0, instr_out=NOP_INSTR, pc_plus4_out=0,
//   imem_req_out=0, drop_q=0, redirect_q=0.
//   An ack for a request abandoned by reset is ignored; the IDLE cycle absorbs it.
//  Handshake:
//   - imem_req_out=1 in REQ only; imem_addr_out=pc, held stable until ack.
//   - No new request starts in the same cycle that an ack is accepted.
//  Redirect target, one cycle after the redirect event:
//   - branch_in: branch_target_in.
//   - jump_in: {pc_plus4_out[31:28], jump_index_in, 2'b00}.
//   - Both set: branch_in wins.
//  FSM:
//   IDLE -> REQ unconditionally (1 cycle, req=0).
//   REQ, no ack:
//    - If a redirect arrives, latch the target into redirect_q and set drop_q.
//    - IF/ID loads a bubble unless stall_in.
//   REQ, ack:
//    - drop_q=1 or redirect this cycle: discard data; pc <= redirect target; clear drop_q; go IDLE.
//    - stall_in=1: data -> hold_q; pc <= pc+4; go HOLD.
//    - Otherwise: IF/ID <= {data, pc+4}, valid_out=1; pc <= pc+4; go IDLE.
//   HOLD:
//    - Redirect: discard hold_q; pc <= target; go IDLE.
//    - Otherwise, stall_in=0: IF/ID <= hold_q, valid_out=1; go IDLE.
//  Flush: branch_in forces IF/ID to a bubble (valid_out=0, instr_out=NOP_INSTR) at the
//   next edge, overriding stall_in.
//  jump_in is honoured only when valid_out=1. The jump itself stays in IF/ID.
//  PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. pc[1:0] is always 2'b00;
//   target bits [1:0] are forced to 0.
//  Peak throughput: 1 instruction per 2 cycles (IDLE gap). Latency from ack to IF/ID: 1 cycle.
// STRUCTURE
//  fetch_pkg: RESET_PC, NOP_INSTR, state encodings (IDLE=2'd0, REQ=2'd1, HOLD=2'd2),
//   opcode J=6'b000_010; shared with Control_Unit.
//  Sub-module fetch_next_pc (combinational): pc+4, jump concatenation, branch>jump priority.
//  FSM, hold_q, drop_q, redirect_q and the IF/ID register live in instruction_fetch.
// TESTING
//  1 Reset, ack same cycle as req, data 32'h2008_0005 @0 -> valid_out=1, op_out=6'h08,
//    pc_plus4_out=4; next request addr=4.
//  2 3-cycle ack latency -> addr held at 8 for all 3 cycles; valid_out=0 until the
//    cycle after ack.
//  3 branch_in=1, target 32'h40, while waiting on addr 8 -> returned word discarded;
//    next request addr 32'h40; valid_out stays 0.
//  4 IF/ID holds J (32'h0800_0010), pc_plus4_out=32'h1000_0008, jump_in=1
//    -> next request addr 32'h1000_0040.
//  5 stall_in=1 for 4 cycles around an ack -> instr_out and pc unchanged while stalled;
//    word appears 1 cycle after release; no word lost or duplicated.
//  6 rst_n_in=0 mid-wait, ack arrives during IDLE -> ack ignored; first request addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared IF-stage definitions: reset PC, bubble instruction, FSM encodings and the J opcode.
// Control_Unit imports the same package so both stages agree on the opcode.
package fetch_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [5:0]  OP_J      = 6'b000_010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC arithmetic for the IF stage: sequential pc+4 and the redirect target.
// A taken branch outranks a jump because the branch belongs to the older instruction.
module fetch_next_pc (
    input  logic [31:0] i_pc,
    input  logic [3:0]  i_ifid_pc_hi,
    input  logic        i_branch,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [25:0] i_jump_index,
    output logic [31:0] o_pc_plus4,
    output logic        o_redirect,
    output logic [31:0] o_target
);

    always_comb begin
        o_pc_plus4 = i_pc + 32'd4;
        o_redirect = i_branch | i_jump;
        if (i_branch) begin
            o_target = {i_branch_target[31:2], 2'b00};
        end else begin
            o_target = {i_ifid_pc_hi, i_jump_index, 2'b00};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, runs the imem req/ack fetch FSM and the IF/ID register.
// Handshake: imem_req_out is high only in REQ; imem_addr_out stays put until an ack is seen.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        stall_in,
    input  logic        branch_in,
    input  logic [31:0] branch_target_in,
    input  logic        jump_in,
    input  logic [25:0] jump_index_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_plus4_out,
    output logic [5:0]  op_out,
    output logic [5:0]  func_out,
    output logic        valid_out,
    output logic [1:0]  dbg_state_out
);

    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_hold;
    logic        r_drop;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    logic        w_jump_take;
    logic [31:0] w_pc_plus4;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_ack;
    logic        w_discard;
    logic        w_take;
    logic        w_hold_release;
    logic [31:0] w_drop_target;

    // A jump is only real when the IF/ID slot it was decoded from is valid.
    assign w_jump_take = jump_in & r_valid;

    fetch_next_pc u_next_pc (
        .i_pc            (r_pc),
        .i_ifid_pc_hi    (r_pc_plus4[31:28]),
        .i_branch        (branch_in),
        .i_branch_target (branch_target_in),
        .i_jump          (w_jump_take),
        .i_jump_index    (jump_index_in),
        .o_pc_plus4      (w_pc_plus4),
        .o_redirect      (w_redirect),
        .o_target        (w_target)
    );

    assign w_ack          = (r_state == ST_REQ) && imem_ack_in;
    assign w_discard      = w_ack && (r_drop || w_redirect);
    assign w_take         = w_ack && !w_discard;
    assign w_hold_release = (r_state == ST_HOLD) && !w_redirect;
    assign w_drop_target  = w_redirect ? w_target : r_redirect_pc;

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: w_state_next = ST_REQ;
            ST_REQ: begin
                if (w_discard) begin
                    w_state_next = ST_IDLE;
                end else if (w_take) begin
                    w_state_next = stall_in ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (w_redirect || !stall_in) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_out  = (r_state == ST_REQ);
        imem_addr_out = r_pc;
        dbg_state_out = r_state;
    end

    // The request address must not move while a fetch is outstanding, so a
    // redirect seen in REQ is parked in r_redirect_pc until the ack retires it.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_pc          <= RESET_PC_AL;
            r_drop        <= 1'b0;
            r_redirect_pc <= 32'd0;
            r_hold        <= NOP_INSTR;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                end
                ST_REQ: begin
                    if (w_discard) begin
                        r_pc   <= w_drop_target;
                        r_drop <= 1'b0;
                    end else if (w_take) begin
                        r_pc <= w_pc_plus4;
                        if (stall_in) begin
                            r_hold <= imem_data_in;
                        end
                    end else if (w_redirect) begin
                        r_drop        <= 1'b1;
                        r_redirect_pc <= w_target;
                    end
                end
                ST_HOLD: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                end
                default: r_pc <= r_pc;
            endcase
        end
    end

    // IF/ID register: flush beats stall; otherwise every unstalled edge
    // either loads a fresh instruction or a bubble, so no word issues twice.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'd0;
        end else if (branch_in) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (!stall_in) begin
            if (w_take) begin
                r_valid    <= 1'b1;
                r_instr    <= imem_data_in;
                r_pc_plus4 <= w_pc_plus4;
            end else if (w_hold_release) begin
                r_valid    <= 1'b1;
                r_instr    <= r_hold;
                r_pc_plus4 <= r_pc;
            end else begin
                r_valid <= 1'b0;
                r_instr <= NOP_INSTR;
            end
        end
    end

    assign instr_out    = r_instr;
    assign pc_plus4_out = r_pc_plus4;
    assign valid_out    = r_valid;
    assign op_out       = r_instr[31:26];
    assign func_out     = r_instr[5:0];

endmodule
